// File: rtl/systolic_array_ctrl.sv
// Job sequencer for a 4x4 8-bit systolic array: accepts A/B, clears the PEs, feeds skewed lanes, drains, captures C.
// Optional SYSTOLIC_ARRAY_CTRL_PERF_EN adds job and busy-cycle counters.
module systolic_array_ctrl #(
   parameter int CLEAR_CYCLES = 1,
   parameter int DRAIN_CYCLES = 4
) (
   input  logic                     i_clk,
   input  logic                     i_srst_n,
   input  logic [3:0][3:0][7:0]     i_a,
   input  logic [3:0][3:0][7:0]     i_b,
   input  logic                     i_in_valid,
   output logic                     o_in_ready,
   output logic [3:0][6:0][7:0]     o_row,
   output logic [3:0][6:0][7:0]     o_col,
   output logic                     o_pe_clear,
   input  logic [3:0][3:0][15:0]    i_c,
   output logic [3:0][3:0][15:0]    o_res,
   output logic                     o_res_valid,
   input  logic                     i_res_ready,
   output logic                     o_busy
`ifdef SYSTOLIC_ARRAY_CTRL_PERF_EN
   ,
   output logic [15:0]              o_job_count,
   output logic [31:0]              o_busy_cycles
`endif
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CLEAR = 3'd1,
      ST_FEED  = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   state_t                  state;
   state_t                  state_nxt;
   logic [15:0]             cnt;
   logic [3:0][3:0][7:0]    a_q;
   logic [3:0][3:0][7:0]    b_q;
   logic [3:0][6:0][7:0]    row_load;
   logic [3:0][6:0][7:0]    col_load;
   logic                    accept;
   logic                    clear_last;
   logic                    feed_last;
   logic                    drain_last;
   logic                    res_hs;

   always_ff @(posedge i_clk) begin
      if (!i_srst_n) state <= ST_IDLE;
      else           state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      accept     = 1'b0;
      clear_last = 1'b0;
      feed_last  = 1'b0;
      drain_last = 1'b0;
      res_hs     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (i_in_valid && o_in_ready) begin
               accept    = 1'b1;
               state_nxt = ST_CLEAR;
            end
         end
         ST_CLEAR: begin
            if (cnt == 16'(CLEAR_CYCLES - 1)) begin
               clear_last = 1'b1;
               state_nxt  = ST_FEED;
            end
         end
         ST_FEED: begin
            if (cnt == 16'd6) begin
               feed_last = 1'b1;
               state_nxt = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (cnt == 16'(DRAIN_CYCLES - 1)) begin
               drain_last = 1'b1;
               state_nxt  = ST_DONE;
            end
         end
         ST_DONE: begin
            if (o_res_valid && i_res_ready) begin
               res_hs    = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Row i is delayed by i slots and column j by j slots, so matching k meet at PE(i,j).
   always_comb begin
      row_load = '0;
      col_load = '0;
      for (int i = 0; i < 4; i++) begin
         for (int k = 0; k < 4; k++) begin
            row_load[i][i+k] = a_q[i][k];
            col_load[i][i+k] = b_q[k][i];
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_srst_n) begin
         o_in_ready  <= 1'b1;
         o_busy      <= 1'b0;
         o_pe_clear  <= 1'b0;
         o_res_valid <= 1'b0;
         o_row       <= '0;
         o_col       <= '0;
         o_res       <= '0;
         a_q         <= '0;
         b_q         <= '0;
         cnt         <= '0;
      end else begin
         o_in_ready <= (state_nxt == ST_IDLE);
         o_busy     <= (state_nxt != ST_IDLE);

         if (accept || clear_last || feed_last || drain_last) begin
            cnt <= '0;
         end else if (state == ST_CLEAR || state == ST_FEED || state == ST_DRAIN) begin
            cnt <= cnt + 16'd1;
         end

         if (accept) begin
            a_q        <= i_a;
            b_q        <= i_b;
            o_pe_clear <= 1'b1;
         end

         if (clear_last) begin
            o_pe_clear <= 1'b0;
            o_row      <= row_load;
            o_col      <= col_load;
         end else if (state == ST_FEED) begin
            // Shift toward the consumed index 0; the seventh shift leaves the lanes empty.
            for (int i = 0; i < 4; i++) begin
               o_row[i] <= o_row[i] >> 8;
               o_col[i] <= o_col[i] >> 8;
            end
         end

         if (drain_last) begin
            o_res       <= i_c;
            o_res_valid <= 1'b1;
         end else if (res_hs) begin
            o_res_valid <= 1'b0;
         end
      end
   end

`ifdef SYSTOLIC_ARRAY_CTRL_PERF_EN
   always_ff @(posedge i_clk) begin
      if (!i_srst_n) begin
         o_job_count   <= '0;
         o_busy_cycles <= '0;
      end else begin
         if (res_hs) o_job_count <= o_job_count + 16'd1;
         if (o_busy && (o_busy_cycles != 32'hFFFF_FFFF)) o_busy_cycles <= o_busy_cycles + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Bench for systolic_array_ctrl: models the external PE array, checks skew, latency, handshakes and C = A x B.
module tb_systolic_array_ctrl;

   typedef logic [3:0][3:0][7:0]  mat8_t;
   typedef logic [3:0][3:0][15:0] mat16_t;
   typedef logic [3:0][6:0][7:0]  lane_t;

   typedef struct {
      string  name;
      mat8_t  a;
      mat8_t  b;
      mat16_t exp;
   } vec_t;

   logic   clk = 1'b0;
   logic   srst_n = 1'b0;
   mat8_t  a_in = '0;
   mat8_t  b_in = '0;
   logic   in_valid = 1'b0;
   logic   in_ready;
   lane_t  row;
   lane_t  col;
   logic   pe_clear;
   mat16_t c_arr = '0;
   mat16_t res;
   logic   res_valid;
   logic   res_ready = 1'b0;
   logic   busy;
`ifdef SYSTOLIC_ARRAY_CTRL_PERF_EN
   logic [15:0] job_count;
   logic [31:0] busy_cycles;
`endif

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   systolic_array_ctrl dut (
      .i_clk(clk), .i_srst_n(srst_n), .i_a(a_in), .i_b(b_in),
      .i_in_valid(in_valid), .o_in_ready(in_ready), .o_row(row), .o_col(col),
      .o_pe_clear(pe_clear), .i_c(c_arr), .o_res(res), .o_res_valid(res_valid),
      .i_res_ready(res_ready), .o_busy(busy)
`ifdef SYSTOLIC_ARRAY_CTRL_PERF_EN
      , .o_job_count(job_count), .o_busy_cycles(busy_cycles)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // External 4x4 output-stationary array: PE(i,j) sees row i delayed by j, column j delayed by i.
   logic [15:0] acc [4][4];
   logic [7:0]  rh  [4][3];
   logic [7:0]  ch  [4][3];
   initial begin
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 4; j++) acc[i][j] = '0;
         for (int d = 0; d < 3; d++) begin rh[i][d] = '0; ch[i][d] = '0; end
      end
   end
   always @(posedge clk) begin
      logic [7:0] av, bv;
      mat16_t     nxt;
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 4; j++) begin
            av = (j == 0) ? row[i][0] : rh[i][j-1];
            bv = (i == 0) ? col[j][0] : ch[j][i-1];
            if (pe_clear) acc[i][j] = '0;
            else          acc[i][j] = acc[i][j] + 16'(av) * 16'(bv);
            nxt[i][j] = acc[i][j];
         end
      end
      for (int i = 0; i < 4; i++) begin
         rh[i][2] = rh[i][1]; rh[i][1] = rh[i][0]; rh[i][0] = row[i][0];
         ch[i][2] = ch[i][1]; ch[i][1] = ch[i][0]; ch[i][0] = col[i][0];
      end
      c_arr <= nxt;
   end

   function automatic mat16_t matmul(input mat8_t a, input mat8_t b);
      mat16_t r;
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 4; j++) begin
            int s = 0;
            for (int k = 0; k < 4; k++) s += int'(a[i][k]) * int'(b[k][j]);
            r[i][j] = 16'(s);
         end
      end
      return r;
   endfunction

   function automatic lane_t skew_row(input mat8_t a);
      lane_t r = '0;
      for (int i = 0; i < 4; i++)
         for (int t = 0; t < 7; t++)
            if (t - i >= 0 && t - i <= 3) r[i][t] = a[i][t-i];
      return r;
   endfunction

   function automatic lane_t skew_col(input mat8_t b);
      lane_t r = '0;
      for (int j = 0; j < 4; j++)
         for (int t = 0; t < 7; t++)
            if (t - j >= 0 && t - j <= 3) r[j][t] = b[t-j][j];
      return r;
   endfunction

   function automatic mat8_t rand_mat();
      mat8_t m;
      for (int i = 0; i < 4; i++)
         for (int k = 0; k < 4; k++) m[i][k] = 8'($urandom);
      return m;
   endfunction

   task automatic chk(input string nm, input logic [271:0] act, input logic [271:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   // Checks from the accept edge through FEED cycle 0.
   task automatic post_accept(input string nm, input mat8_t a, input mat8_t b);
      chk({nm, "_clear_hi"}, pe_clear, 1'b1);
      chk({nm, "_busy"}, busy, 1'b1);
      chk({nm, "_in_ready_lo"}, in_ready, 1'b0);
      chk({nm, "_lanes_zero_in_clear"}, {row, col}, '0);
      tick();
      chk({nm, "_clear_one_cycle"}, pe_clear, 1'b0);
      chk({nm, "_row_skew"}, row, skew_row(a));
      chk({nm, "_col_skew"}, col, skew_col(b));
   endtask

   task automatic start_job(input string nm, input mat8_t a, input mat8_t b, output int acc_cyc);
      int n = 0;
      while (!in_ready && n < 200) begin tick(); n++; end
      chk({nm, "_ready_timeout"}, (n < 200), 1'b1);
      a_in = a; b_in = b; in_valid = 1'b1;
      tick();
      acc_cyc = cyc;
      in_valid = 1'b0;
      a_in = rand_mat(); b_in = rand_mat();
      post_accept(nm, a, b);
   endtask

   // Result is due on the 13th edge counting the accept edge, i.e. 12 edges after it.
   task automatic wait_valid(input string nm, input mat16_t exp);
      int n = 1;
      while (!res_valid && n < 100) begin
         tick(); n++;
         if (n == 9) chk({nm, "_lanes_empty_after_feed"}, {row, col}, '0);
      end
      chk({nm, "_latency"}, n, 12);
      chk({nm, "_result"}, res, exp);
      chk({nm, "_in_ready_lo_done"}, in_ready, 1'b0);
   endtask

   task automatic release_res(input string nm);
      res_ready = 1'b1;
      tick();
      chk({nm, "_hs_flags"}, {res_valid, in_ready, busy}, 3'b010);
   endtask

   task automatic run_job(input string nm, input mat8_t a, input mat8_t b,
                          input mat16_t exp, input int hold, output int acc_cyc);
      res_ready = (hold == 0);
      start_job(nm, a, b, acc_cyc);
      wait_valid(nm, exp);
      for (int h = 0; h < hold; h++) begin
         tick();
         chk({nm, "_hold"}, {res_valid, in_ready, res}, {1'b1, 1'b0, exp});
      end
      release_res(nm);
   endtask

   vec_t vecs[3];

   initial begin
      int acc_c, prev_c, seen;
      mat8_t a1, b1, a2, b2;

      // Directed vectors
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 4; j++) begin
            vecs[0].a[i][j] = (i == j) ? 8'd1 : 8'd0;
            vecs[0].b[i][j] = 8'(4 * i + j + 1);
            vecs[0].exp[i][j] = 16'(4 * i + j + 1);
            vecs[1].a[i][j] = 8'd1;
            vecs[1].b[i][j] = 8'd2;
            vecs[1].exp[i][j] = 16'd8;
            vecs[2].a[i][j] = 8'd255;
            vecs[2].b[i][j] = 8'd255;
            vecs[2].exp[i][j] = 16'hF804;   // 4*255*255 = 260100 = 0x3F804, wraps to 0xF804
         end
      end
      vecs[0].name = "identity";
      vecs[1].name = "skew";
      vecs[2].name = "overflow";

      repeat (3) tick();
      chk("rst_flags", {in_ready, busy, pe_clear, res_valid}, 4'b1000);
      chk("rst_data", {row, col, res}, '0);
      srst_n = 1'b1;
      tick();

      // Back-to-back table jobs with the consumer always ready
      prev_c = 0;
      for (int v = 0; v < 3; v++) begin
         run_job(vecs[v].name, vecs[v].a, vecs[v].b, vecs[v].exp, 0, acc_c);
         if (v > 0) chk({vecs[v].name, "_throughput"}, acc_c - prev_c, 14);
         prev_c = acc_c;
      end
`ifdef SYSTOLIC_ARRAY_CTRL_PERF_EN
      chk("perf_job_count", job_count, 16'd3);
      chk("perf_busy_cycles", busy_cycles, 32'd39);
`endif

      // Backpressure: result held 20 cycles while a second request waits
      a1 = rand_mat(); b1 = rand_mat(); a2 = rand_mat(); b2 = rand_mat();
      res_ready = 1'b0;
      start_job("bp1", a1, b1, acc_c);
      wait_valid("bp1", matmul(a1, b1));
      a_in = a2; b_in = b2; in_valid = 1'b1;
      for (int h = 0; h < 20; h++) begin
         tick();
         chk("bp_hold", {res_valid, in_ready, busy, res}, {3'b101, matmul(a1, b1)});
      end
      res_ready = 1'b1;
      tick();
      chk("bp_release", {res_valid, in_ready, busy}, 3'b010);
      tick();
      in_valid = 1'b0;
      post_accept("bp2", a2, b2);
      wait_valid("bp2", matmul(a2, b2));
      release_res("bp2");

      // Reset during FEED cycle 3 aborts the job
      a1 = rand_mat(); b1 = rand_mat();
      start_job("abort", a1, b1, acc_c);
      repeat (3) tick();
      srst_n = 1'b0;
      tick();
      srst_n = 1'b1;
      chk("abort_flags", {in_ready, busy, pe_clear, res_valid}, 4'b1000);
      chk("abort_lanes", {row, col}, '0);
      seen = 0;
      for (int h = 0; h < 20; h++) begin
         tick();
         if (res_valid || busy) seen++;
      end
      chk("abort_no_result", seen, 0);
      a1 = rand_mat(); b1 = rand_mat();
      run_job("after_abort", a1, b1, matmul(a1, b1), 0, acc_c);

      // Randomised jobs with random consumer stalls
      for (int r = 0; r < 10; r++) begin
         a1 = rand_mat(); b1 = rand_mat();
         if (r == 9) begin a1 = '1; b1 = '1; end
         run_job($sformatf("rand%0d", r), a1, b1, matmul(a1, b1), int'($urandom_range(0, 3)), acc_c);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
